// File: rtl/canonical_pkg.sv
// Shared constants and types for the canonical-form output collector.
// Literal encoding, FSM states and the per-row literal vector type.
package canonical_pkg;

    localparam int unsigned NUM_QUBIT      = 4;
    localparam int unsigned MAX_VECTOR     = 1 << NUM_QUBIT;
    localparam int unsigned TIMEOUT_CYCLES = 4 * NUM_QUBIT;
    localparam int unsigned ROW_W          = $clog2(NUM_QUBIT);
    localparam int unsigned CYC_W          = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned LIT_W          = 2 * NUM_QUBIT;

    localparam logic [1:0] LIT_I = 2'd0;
    localparam logic [1:0] LIT_X = 2'd1;
    localparam logic [1:0] LIT_Z = 2'd2;
    localparam logic [1:0] LIT_Y = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef logic [NUM_QUBIT-1:0][1:0] row_lit_t;

endpackage

// File: rtl/canonical_collect_row.sv
// One tableau row: literals and phases, written when the shared write
// index matches this row, cleared as a whole on restart.
module canonical_collect_row
    import canonical_pkg::*;
#(
    parameter int unsigned ROW_IDX = 0
) (
    input  logic                  clk,
    input  logic                  rst_new,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [ROW_W-1:0]      idx_i,
    input  logic [LIT_W-1:0]      lit_i,
    input  logic [MAX_VECTOR-1:0] phase_i,
    output logic [LIT_W-1:0]      lit_o,
    output logic [MAX_VECTOR-1:0] phase_o
);

    localparam logic [ROW_W-1:0] MY_IDX = ROW_W'(ROW_IDX);

    row_lit_t              lit_q;
    logic [MAX_VECTOR-1:0] phase_q;

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            lit_q   <= '0;
            phase_q <= '0;
        end else if (clr_i) begin
            lit_q   <= '0;
            phase_q <= '0;
        end else if (we_i && (idx_i == MY_IDX)) begin
            lit_q   <= lit_i;
            phase_q <= phase_i;
        end
    end

    assign lit_o   = lit_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/canonical_collect.sv
// Collects flagged rows from the canonical-form stream into a parallel
// tableau; reports completion (done/tab_valid) or timeout (error).
//
// state      | meaning
// IDLE       | waiting for arm; error may be holding a timeout
// COLLECT    | accepting flagged rows, timeout counter running
// DONE       | tableau complete and held until the next arm
module canonical_collect
    import canonical_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_new,
    input  logic                            arm,
    input  logic [LIT_W-1:0]                literals_in,
    input  logic [MAX_VECTOR-1:0]           phase_in,
    input  logic                            flag_in,
    output logic [NUM_QUBIT*LIT_W-1:0]      literals_tab,
    output logic [NUM_QUBIT*MAX_VECTOR-1:0] phase_tab,
    output logic [31:0]                     row_count,
    output logic                            busy,
    output logic                            tab_valid,
    output logic                            done,
    output logic                            error
);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]      ROWS_FULL = 32'(NUM_QUBIT);

    state_t           state_q, state_d;
    logic [31:0]      row_count_q, row_count_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             clr;
    logic             wr;

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            state_q     <= ST_IDLE;
            row_count_q <= '0;
            cyc_q       <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_count_q <= row_count_d;
            cyc_q       <= cyc_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // arm is evaluated first in every state so it always beats a write
    always_comb begin
        state_d     = state_q;
        row_count_d = row_count_q;
        cyc_d       = cyc_q;
        done_d      = 1'b0;
        error_d     = error_q;
        clr         = 1'b0;
        wr          = 1'b0;
        if (arm) begin
            state_d     = ST_COLLECT;
            row_count_d = '0;
            cyc_d       = '0;
            error_d     = 1'b0;
            clr         = 1'b1;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    cyc_d = cyc_q + CYC_W'(1);
                    if (flag_in && (row_count_q < ROWS_FULL)) begin
                        wr          = 1'b1;
                        row_count_d = row_count_q + 32'd1;
                    end
                    // completion outranks a simultaneous timeout
                    if (row_count_d == ROWS_FULL) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (cyc_q == CYC_LAST) begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: state_d = state_q;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == ST_COLLECT);
        tab_valid = (state_q == ST_DONE);
    end

    for (genvar r = 0; r < NUM_QUBIT; r++) begin : g_row
        canonical_collect_row #(.ROW_IDX(r)) u_row (
            .clk     (clk),
            .rst_new (rst_new),
            .clr_i   (clr),
            .we_i    (wr),
            .idx_i   (row_count_q[ROW_W-1:0]),
            .lit_i   (literals_in),
            .phase_i (phase_in),
            .lit_o   (literals_tab[r*LIT_W +: LIT_W]),
            .phase_o (phase_tab[r*MAX_VECTOR +: MAX_VECTOR])
        );
    end

    assign row_count = row_count_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_canonical_collect.sv
// Directed bench for canonical_collect: flagged rows are queued as expected
// tableau rows when driven and popped for comparison when the DUT finishes.
module tb_canonical_collect;
    import canonical_pkg::*;

    logic         clk = 1'b0;
    logic         rst_new;
    logic         arm;
    logic [7:0]   literals_in;
    logic [15:0]  phase_in;
    logic         flag_in;
    logic [31:0]  literals_tab;
    logic [63:0]  phase_tab;
    logic [31:0]  row_count;
    logic         busy, tab_valid, done, error;

    typedef struct packed {
        logic [7:0]  lit;
        logic [15:0] ph;
    } row_t;

    row_t        exp_q[$];
    logic [31:0] last_lit;
    logic [63:0] last_ph;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    canonical_collect dut (
        .clk          (clk),
        .rst_new      (rst_new),
        .arm          (arm),
        .literals_in  (literals_in),
        .phase_in     (phase_in),
        .flag_in      (flag_in),
        .literals_tab (literals_tab),
        .phase_tab    (phase_tab),
        .row_count    (row_count),
        .busy         (busy),
        .tab_valid    (tab_valid),
        .done         (done),
        .error        (error)
    );

    function automatic logic [7:0] mk(input logic [1:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] l, input logic [15:0] p, input logic f, input bit push);
        literals_in = l;
        phase_in    = p;
        flag_in     = f;
        if (push) exp_q.push_back('{lit: l, ph: p});
        step();
        flag_in = 1'b0;
    endtask

    task automatic idle(input int n);
        flag_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // rows still queued are the expected tableau contents, in order
    task automatic chk_tab(input string tag);
        logic [31:0] el;
        logic [63:0] ep;
        int r;
        row_t e;
        el = '0;
        ep = '0;
        r  = 0;
        while (exp_q.size() > 0 && r < 4) begin
            e = exp_q.pop_front();
            el[r*8 +: 8]   = e.lit;
            ep[r*16 +: 16] = e.ph;
            r++;
        end
        last_lit = el;
        last_ph  = ep;
        chk({tag, "_lit"}, 64'(literals_tab), 64'(el));
        chk({tag, "_ph"}, phase_tab, ep);
    endtask

    initial begin
        rst_new     = 1'b1;
        arm         = 1'b0;
        literals_in = '0;
        phase_in    = '0;
        flag_in     = 1'b0;
        #2;
        chk("rst_lit", 64'(literals_tab), 64'h0);
        chk("rst_ph", phase_tab, 64'h0);
        chk("rst_cnt", 64'(row_count), 64'h0);
        chk("rst_flags", {60'h0, busy, tab_valid, done, error}, 64'h0);
        @(posedge clk);
        #1;
        rst_new = 1'b0;

        // flags ignored in IDLE
        send(mk(LIT_Y, LIT_Y, LIT_Y, LIT_Y), 16'hffff, 1'b1, 1'b0);
        chk("idle_cnt", 64'(row_count), 64'h0);

        // back-to-back rows
        do_arm();
        chk("t1_busy", 64'(busy), 64'h1);
        send(mk(LIT_X, LIT_I, LIT_I, LIT_I), 16'h0000, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_X, LIT_I, LIT_I), 16'h0000, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_I, LIT_Z, LIT_I), 16'h0001, 1'b1, 1'b1);
        chk("t1_done_early", 64'(done), 64'h0);
        send(mk(LIT_I, LIT_I, LIT_I, LIT_Y), 16'h0000, 1'b1, 1'b1);
        chk("t1_done", {62'h0, done, tab_valid}, 64'h3);
        chk("t1_cnt", 64'(row_count), 64'h4);
        chk("t1_ph20", 64'(phase_tab[32]), 64'h1);
        chk_tab("t1");
        idle(1);
        chk("t1_pulse", {62'h0, done, tab_valid}, 64'h1);

        // DONE holds the tableau
        send(mk(LIT_Z, LIT_Z, LIT_Z, LIT_Z), 16'h00ff, 1'b1, 1'b0);
        send(mk(LIT_Y, LIT_Z, LIT_Y, LIT_Z), 16'hff00, 1'b1, 1'b0);
        chk("t5_lit", 64'(literals_tab), 64'(last_lit));
        chk("t5_ph", phase_tab, last_ph);
        chk("t5_cnt", 64'(row_count), 64'h4);
        do_arm();
        chk("t5_busy", {62'h0, busy, tab_valid}, 64'h2);
        chk_tab("t5_clr");

        // interleaved unflagged rows
        for (int i = 0; i < 4; i++) begin
            send(mk(LIT_X, LIT_X, LIT_X, LIT_X), 16'hffff, 1'b0, 1'b0);
            send(8'(8'h1 << (2 * i)), 16'(i), 1'b1, 1'b1);
        end
        chk("t2_done", {62'h0, done, tab_valid}, 64'h3);
        chk("t2_cnt", 64'(row_count), 64'h4);
        chk_tab("t2");

        // timeout with partial rows
        do_arm();
        send(mk(LIT_Z, LIT_I, LIT_I, LIT_I), 16'h8000, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_Y, LIT_I, LIT_I), 16'h0003, 1'b1, 1'b1);
        idle(13);
        chk("t3_pre", {62'h0, busy, error}, 64'h2);
        idle(1);
        chk("t3_err", {60'h0, busy, tab_valid, done, error}, 64'h1);
        chk("t3_cnt", 64'(row_count), 64'h2);
        chk_tab("t3");
        do_arm();
        chk("t3_clr", {62'h0, busy, error}, 64'h2);

        // restart mid-collect; flagged row in the arm cycle is dropped
        send(mk(LIT_Y, LIT_I, LIT_I, LIT_I), 16'h0010, 1'b1, 1'b1);
        send(mk(LIT_Y, LIT_Y, LIT_I, LIT_I), 16'h0020, 1'b1, 1'b1);
        literals_in = mk(LIT_Z, LIT_Z, LIT_Z, LIT_Z);
        phase_in    = 16'hbeef;
        flag_in     = 1'b1;
        exp_q.delete();
        do_arm();
        flag_in = 1'b0;
        chk("t4_cnt", 64'(row_count), 64'h0);
        chk("t4_lit0", 64'(literals_tab), 64'h0);
        chk("t4_busy", 64'(busy), 64'h1);
        send(mk(LIT_I, LIT_I, LIT_I, LIT_X), 16'h0100, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_I, LIT_X, LIT_I), 16'h0200, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_X, LIT_I, LIT_I), 16'h0400, 1'b1, 1'b1);
        send(mk(LIT_X, LIT_I, LIT_I, LIT_I), 16'h0800, 1'b1, 1'b1);
        chk("t4_done", {62'h0, done, tab_valid}, 64'h3);
        chk_tab("t4");

        // completion on the last allowed COLLECT cycle beats timeout
        do_arm();
        idle(12);
        send(mk(LIT_Y, LIT_I, LIT_I, LIT_I), 16'h0001, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_Y, LIT_I, LIT_I), 16'h0002, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_I, LIT_Y, LIT_I), 16'h0004, 1'b1, 1'b1);
        send(mk(LIT_I, LIT_I, LIT_I, LIT_Y), 16'h0008, 1'b1, 1'b1);
        chk("t7_edge", {60'h0, busy, tab_valid, done, error}, 64'h6);
        chk_tab("t7");

        // asynchronous reset mid-collect
        do_arm();
        send(mk(LIT_X, LIT_Y, LIT_Z, LIT_I), 16'h1111, 1'b1, 1'b1);
        send(mk(LIT_Y, LIT_Z, LIT_I, LIT_X), 16'h2222, 1'b1, 1'b1);
        send(mk(LIT_Z, LIT_I, LIT_X, LIT_Y), 16'h3333, 1'b1, 1'b1);
        chk("t6_pre", 64'(row_count), 64'h3);
        #2;
        rst_new = 1'b1;
        #1;
        exp_q.delete();
        chk("t6_lit", 64'(literals_tab), 64'h0);
        chk("t6_ph", phase_tab, 64'h0);
        chk("t6_out", {28'h0, row_count, busy, tab_valid, done, error}, 64'h0);
        @(posedge clk);
        #1;
        rst_new = 1'b0;
        send(mk(LIT_I, LIT_I, LIT_I, LIT_Y), 16'h0000, 1'b1, 1'b0);
        send(mk(LIT_I, LIT_I, LIT_I, LIT_Y), 16'h0000, 1'b1, 1'b0);
        idle(2);
        chk("t6_nodone", {60'h0, busy, tab_valid, done, error}, 64'h0);
        chk("t6_cnt", 64'(row_count), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/canonical_collect.md
# canonical_collect

Stream-to-tableau receiver on the output side of the canonical-form block. It captures the row stream (literals, per-vector phase and flag) emitted after canonicalisation and keeps only rows with flag set. It reassembles them in arrival order into a parallel num_qubit-row tableau and signals completion or timeout to the downstream measurement/emulation stage.

## Interface
- num_qubit, 4, qubits per row and number of valid rows to collect
- max_vector, 2**num_qubit, phase bits per row (one per vector pair)
- timeout_cycles, 4*num_qubit, COLLECT cycles allowed before error
- clk  in  1  clock, rising edge
- rst_new  in  1  reset, asynchronous, active-high
- arm  in  1  start/restart capture (level sampled each cycle)
- literals_in  in  [1:0] x num_qubit  streamed row literals (0=I,1=X,2=Z,3=Y)
- phase_in  in  1 x max_vector  streamed row phases
- flag_in  in  1  row valid qualifier (already gated by second stage)
- literals_tab  out  [1:0] x num_qubit x num_qubit  captured rows [row][col]
- phase_tab  out  1 x num_qubit x max_vector  captured phases [row][pair]
- row_count  out  32  valid rows captured so far
- busy  out  1  high in COLLECT
- tab_valid  out  1  high in DONE
- done  out  1  one-cycle pulse on entering DONE
- error  out  1  sticky timeout flag, cleared by arm or reset

## Operation
- States: IDLE, COLLECT, DONE; 2-bit encoding; reset -> IDLE.
- IDLE: flag_in ignored; arm=1 -> COLLECT, row_count<=0, cycle counter<=0, literals_tab/phase_tab <= all 0, error<=0.
- COLLECT: on flag_in=1 write literals_in/phase_in to row row_count, row_count+1. If this write makes row_count==num_qubit -> DONE, done<=1 for one cycle. Rows with flag_in=0 are skipped and leave no gap.
- COLLECT timeout: the cycle counter increments every COLLECT cycle. If it reaches timeout_cycles-1 without completion -> IDLE with error<=1. Partial rows stay visible, tab_valid=0.
- Completion and timeout in the same cycle: completion wins, error stays 0.
- DONE: tableau held, flag_in ignored; arm=1 -> COLLECT with full clear as from IDLE.
- arm=1 in COLLECT: restart (clear, counters to 0); a flag_in in that same cycle is discarded.
- arm takes priority over any write in the same cycle in every state.
- row_count is never greater than num_qubit. Writes never exceed row num_qubit-1.
- Reset values: all tableau bits 0, row_count 0, busy 0, tab_valid 0, done 0, error 0.
- Reset mid-COLLECT: immediate asynchronous return to reset values, no partial tableau kept.

## Timing
- All outputs are registered except busy and tab_valid, which decode the state register.
- First row can be captured in the cycle after arm is sampled.
- Latency: the last valid row is sampled on edge N. State is DONE and done=1 after edge N, and the tableau is stable from that cycle.
- Minimum arm-to-done: num_qubit+1 edges with back-to-back flagged rows.
- Timeout: error rises after exactly timeout_cycles COLLECT cycles without completion.
- The upstream stream has no backpressure. The block accepts one row per cycle unconditionally.

## Structure
- Shared package (canonical_pkg): literal encoding constants (LIT_I/X/Z/Y), state enum, the row-literal typedef [1:0] x num_qubit.
- One natural sub-module: canonical_collect_row, a single-row register with write-enable, clear and row-index match. Instantiate it num_qubit times via generate.
- The FSM and counters stay in the top module.

## Test plan
- Reset then arm, then 4 flagged rows on consecutive cycles (XIII, IXII, IIZI, IIIY; phase[0]=1 on row 2) -> done pulses once after the 4th edge. Tableau matches in order, phase_tab[2][0]=1, row_count=4.
- Same rows interleaved with flag_in=0 rows (XXXX, phase all 1) -> the unflagged rows never appear; done follows the 4th flagged row.
- Arm, then only 2 flagged rows -> error=1 after 16 COLLECT cycles, state IDLE, rows 0-1 filled, tab_valid=0. A following arm clears error.
- Arm asserted again after 2 rows, with a flagged row in the same cycle -> tableau cleared, row_count=0, that row discarded, the next 4 rows complete normally.
- In DONE, drive further flagged rows -> tableau and row_count unchanged. Then arm -> busy=1 and the tableau is cleared.
- Assert rst_new asynchronously after 3 rows captured -> all outputs 0 immediately. No done pulse follows without a new arm.
